// File: rtl/rf_write_arbiter_pkg.sv
// Shared sizes, requester indices and the write-request type for the
// register-file write-port arbiter.
package rf_write_arbiter_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] wn;
    logic [DW-1:0] wd;
  } wr_req_t;

  // One-hot register mask; used for scoreboard set/clear vectors.
  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] wn);
    return NREG'(1) << wn;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of requester handshakes, issue tracking, rf write port and busy map.
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
  ();

  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_wn;
  logic [DW-1:0]   a_wd;

  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_wn;
  logic [DW-1:0]   b_wd;

  logic            issue_valid;
  logic [AW-1:0]   issue_wn;

  logic            rf_w;
  logic [AW-1:0]   rf_wn;
  logic [DW-1:0]   rf_wd;

  logic [NREG-1:0] busy;

  modport slave (
    input  a_valid, a_wn, a_wd,
    input  b_valid, b_wn, b_wd,
    input  issue_valid, issue_wn,
    output a_ready, b_ready,
    output rf_w, rf_wn, rf_wd,
    output busy
  );

  modport master (
    output a_valid, a_wn, a_wd,
    output b_valid, b_wn, b_wd,
    output issue_valid, issue_wn,
    input  a_ready, b_ready,
    input  rf_w, rf_wn, rf_wd,
    input  busy
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the side preferred on a tie
// and flips to the loser after every grant.
module rr_arb2
  import rf_write_arbiter_pkg::*;
  (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
  );

  logic ptr_reg;

  // Grants are suppressed while reset is asserted so nothing is accepted
  // that could never be written.
  always_comb begin
    grant        = 2'b00;
    grant[REQ_A] = !rst && req[REQ_A] && (!req[REQ_B] || ptr_reg == REQ_A);
    grant[REQ_B] = !rst && req[REQ_B] && (!req[REQ_A] || ptr_reg == REQ_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= REQ_A;
    end else if (grant[REQ_A]) begin
      ptr_reg <= REQ_B;
    end else if (grant[REQ_B]) begin
      ptr_reg <= REQ_A;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single rf write port between the WB stage (A) and the
// long-latency unit (B), and tracks registers with outstanding B writes.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
  (
    input  logic         clk,
    input  logic         rst,
    rf_write_arbiter_if.slave bus
  );

  logic [1:0]      req;
  logic [1:0]      grant;
  wr_req_t         req_a;
  wr_req_t         req_b;
  wr_req_t         win;

  logic            rf_w_reg;
  logic [AW-1:0]   rf_wn_reg;
  logic [DW-1:0]   rf_wd_reg;

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign req_a = '{valid: bus.a_valid, wn: bus.a_wn, wd: bus.a_wd};
  assign req_b = '{valid: bus.b_valid, wn: bus.b_wn, wd: bus.b_wd};

  always_comb begin
    req        = 2'b00;
    req[REQ_A] = req_a.valid;
    req[REQ_B] = req_b.valid;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  assign bus.a_ready = grant[REQ_A];
  assign bus.b_ready = grant[REQ_B];

  always_comb begin
    win = '0;
    if (grant[REQ_A]) begin
      win = req_a;
    end else if (grant[REQ_B]) begin
      win = req_b;
    end
  end

  // A grant to r0 still uses the slot but must not raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_w_reg  <= 1'b0;
      rf_wn_reg <= '0;
      rf_wd_reg <= '0;
    end else begin
      rf_w_reg <= win.valid && (win.wn != '0);
      if (win.valid) begin
        rf_wn_reg <= win.wn;
        rf_wd_reg <= win.wd;
      end
    end
  end

  assign set_mask = bus.issue_valid ? reg_onehot(bus.issue_wn) : '0;
  assign clr_mask = grant[REQ_B]    ? reg_onehot(bus.b_wn)     : '0;

  // A new issue outranks a completing write to the same register.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = set_mask[gi] | (busy_reg[gi] & ~clr_mask[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign bus.rf_w  = rf_w_reg;
  assign bus.rf_wn = rf_wn_reg;
  assign bus.rf_wd = rf_wd_reg;
  assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: handshake, round-robin, scoreboard,
// register-0 handling and asynchronous reset mid-operation.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.a_valid     = 1'b0;
    bus.a_wn        = '0;
    bus.a_wd        = '0;
    bus.b_valid     = 1'b0;
    bus.b_wn        = '0;
    bus.b_wd        = '0;
    bus.issue_valid = 1'b0;
    bus.issue_wn    = '0;

    // Reset state; a request during reset must not be accepted.
    step();
    bus.a_valid = 1'b1;
    bus.a_wn    = 5'd1;
    bus.a_wd    = 32'h1;
    step();
    chk("rst_rf_w",    64'(bus.rf_w),    64'd0);
    chk("rst_rf_wn",   64'(bus.rf_wn),   64'd0);
    chk("rst_rf_wd",   64'(bus.rf_wd),   64'd0);
    chk("rst_busy",    64'(bus.busy),    64'd0);
    chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
    bus.a_valid = 1'b0;
    rst         = 1'b0;
    $display("txn reset released");

    // Single A write.
    bus.a_valid = 1'b1;
    bus.a_wn    = 5'd5;
    bus.a_wd    = 32'h25;
    #1;
    chk("t1_a_ready", 64'(bus.a_ready), 64'd1);
    chk("t1_b_ready", 64'(bus.b_ready), 64'd0);
    step();
    bus.a_valid = 1'b0;
    chk("t1_rf_w",  64'(bus.rf_w),  64'd1);
    chk("t1_rf_wn", 64'(bus.rf_wn), 64'd5);
    chk("t1_rf_wd", 64'(bus.rf_wd), 64'h25);
    $display("txn A wn=5 wd=25 rf_w=%0d", bus.rf_w);
    step();
    chk("t1_idle_rf_w",  64'(bus.rf_w),  64'd0);
    chk("t1_hold_rf_wn", 64'(bus.rf_wn), 64'd5);

    // Single B write; pointer returns to A.
    bus.b_valid = 1'b1;
    bus.b_wn    = 5'd6;
    bus.b_wd    = 32'h66;
    #1;
    chk("tb_b_ready", 64'(bus.b_ready), 64'd1);
    step();
    bus.b_valid = 1'b0;
    chk("tb_rf_wn", 64'(bus.rf_wn), 64'd6);
    $display("txn B wn=6 wd=66 rf_w=%0d", bus.rf_w);

    // Both valid: A, B, A, B with fresh requests after each acceptance.
    bus.a_valid = 1'b1; bus.a_wn = 5'd3; bus.a_wd = 32'h9;
    bus.b_valid = 1'b1; bus.b_wn = 5'd4; bus.b_wd = 32'h16;
    #1;
    chk("rr0_a_ready", 64'(bus.a_ready), 64'd1);
    chk("rr0_b_ready", 64'(bus.b_ready), 64'd0);
    step();
    bus.a_wn = 5'd10; bus.a_wd = 32'hA0;
    chk("rr0_rf_wn", 64'(bus.rf_wn), 64'd3);
    chk("rr0_rf_wd", 64'(bus.rf_wd), 64'h9);
    $display("txn RR grant A wn=3");
    #1;
    chk("rr1_b_ready", 64'(bus.b_ready), 64'd1);
    chk("rr1_a_ready", 64'(bus.a_ready), 64'd0);
    step();
    bus.b_wn = 5'd11; bus.b_wd = 32'hB0;
    chk("rr1_rf_wn", 64'(bus.rf_wn), 64'd4);
    chk("rr1_rf_wd", 64'(bus.rf_wd), 64'h16);
    $display("txn RR grant B wn=4");
    #1;
    chk("rr2_a_ready", 64'(bus.a_ready), 64'd1);
    step();
    bus.a_valid = 1'b0;
    chk("rr2_rf_wn", 64'(bus.rf_wn), 64'd10);
    $display("txn RR grant A wn=10");
    #1;
    chk("rr3_b_ready", 64'(bus.b_ready), 64'd1);
    step();
    bus.b_valid = 1'b0;
    chk("rr3_rf_wn", 64'(bus.rf_wn), 64'd11);
    chk("rr3_rf_wd", 64'(bus.rf_wd), 64'hB0);
    $display("txn RR grant B wn=11");
    step();
    chk("rr_idle_rf_w", 64'(bus.rf_w), 64'd0);

    // Issue marks busy; B completion clears it on the write edge.
    bus.issue_valid = 1'b1;
    bus.issue_wn    = 5'd7;
    step();
    bus.issue_valid = 1'b0;
    chk("sb_set", 64'(bus.busy), 64'h80);
    $display("txn issue wn=7 busy=%0h", bus.busy);
    bus.b_valid = 1'b1;
    bus.b_wn    = 5'd7;
    bus.b_wd    = 32'h77;
    #1;
    chk("sb_b_ready", 64'(bus.b_ready), 64'd1);
    step();
    bus.b_valid = 1'b0;
    chk("sb_clr",     64'(bus.busy),  64'h0);
    chk("sb_clr_rfw", 64'(bus.rf_w),  64'd1);
    chk("sb_clr_rfd", 64'(bus.rf_wd), 64'h77);
    $display("txn B wn=7 busy=%0h", bus.busy);

    // Set and clear of the same register on one edge: set wins.
    bus.issue_valid = 1'b1;
    bus.issue_wn    = 5'd7;
    step();
    chk("sc_pre", 64'(bus.busy), 64'h80);
    bus.b_valid = 1'b1;
    bus.b_wn    = 5'd7;
    bus.b_wd    = 32'h78;
    #1;
    chk("sc_b_ready", 64'(bus.b_ready), 64'd1);
    step();
    bus.issue_valid = 1'b0;
    bus.b_valid     = 1'b0;
    chk("sc_busy", 64'(bus.busy),  64'h80);
    chk("sc_rfwd", 64'(bus.rf_wd), 64'h78);
    $display("txn issue+B wn=7 busy=%0h", bus.busy);

    // Register 0: accepted, no write, issue ignored, pointer still advances.
    bus.a_valid     = 1'b1;
    bus.a_wn        = 5'd0;
    bus.a_wd        = 32'hFFFF;
    bus.issue_valid = 1'b1;
    bus.issue_wn    = 5'd0;
    #1;
    chk("r0_a_ready", 64'(bus.a_ready), 64'd1);
    step();
    bus.issue_valid = 1'b0;
    chk("r0_rf_w", 64'(bus.rf_w), 64'd0);
    chk("r0_busy", 64'(bus.busy), 64'h80);
    $display("txn A wn=0 rf_w=%0d", bus.rf_w);
    bus.a_wn    = 5'd1;
    bus.a_wd    = 32'h11;
    bus.b_valid = 1'b1;
    bus.b_wn    = 5'd2;
    bus.b_wd    = 32'h22;
    #1;
    chk("r0_ptr_b", 64'(bus.b_ready), 64'd1);
    chk("r0_ptr_a", 64'(bus.a_ready), 64'd0);
    step();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    chk("r0_next_wn", 64'(bus.rf_wn), 64'd2);

    // Async reset mid-cycle with busy[9] set and B waiting.
    bus.a_valid     = 1'b1;
    bus.a_wn        = 5'd8;
    bus.a_wd        = 32'h88;
    bus.issue_valid = 1'b1;
    bus.issue_wn    = 5'd9;
    step();
    bus.a_valid     = 1'b0;
    bus.issue_valid = 1'b0;
    chk("ar_pre_busy", 64'(bus.busy), 64'h280);
    chk("ar_pre_rfw",  64'(bus.rf_w), 64'd1);
    bus.b_valid = 1'b1;
    bus.b_wn    = 5'd9;
    bus.b_wd    = 32'h99;
    #1;
    chk("ar_pre_bready", 64'(bus.b_ready), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_rf_w",    64'(bus.rf_w),    64'd0);
    chk("ar_busy",    64'(bus.busy),    64'h0);
    chk("ar_b_ready", 64'(bus.b_ready), 64'd0);
    chk("ar_rf_wn",   64'(bus.rf_wn),   64'd0);
    step();
    chk("ar_hold_rfw", 64'(bus.rf_w),    64'd0);
    chk("ar_hold_brd", 64'(bus.b_ready), 64'd0);
    rst = 1'b0;
    $display("txn async reset busy=%0h", bus.busy);
    #1;
    chk("ar_post_bready", 64'(bus.b_ready), 64'd1);
    step();
    bus.b_valid = 1'b0;
    chk("ar_post_rfw",  64'(bus.rf_w),  64'd1);
    chk("ar_post_rfwn", 64'(bus.rf_wn), 64'd9);
    chk("ar_post_rfwd", 64'(bus.rf_wd), 64'h99);
    chk("ar_post_busy", 64'(bus.busy),  64'h0);
    $display("txn B wn=9 after reset rf_w=%0d", bus.rf_w);
    step();
    chk("ar_idle_rfw", 64'(bus.rf_w), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
